pe_config_loader: RTL and testbench
===================================

# pe_config_loader

Configuration sequencer that sits directly upstream of an array of PEs. It accepts a stream of `INST_W`-bit PE instruction words over a valid/ready handshake, writes them into each PE's configuration buffer through a broadcast instruction bus and per-PE one-hot `init` strobes, then replays the loaded contexts by driving a broadcast `run` strobe. It also clears the PEs before every load, so every PE's buffer index and run index restart at 0.

## Interface

Parameters:
- `NUM_PE`, 4: number of PEs driven; one `pe_init` bit per PE.
- `INST_W`, 28: PE instruction width; matches the PE instruction port.
- `DEPTH`, 16: PE configuration buffer depth; maximum legal `ctx_len`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begin a load-and-run job; sampled only in IDLE.
- `ctx_len` input $clog2(DEPTH+1): contexts per PE; latched on accepted `start`.
- `in_valid` input 1: instruction word valid.
- `in_data` input INST_W: instruction word.
- `in_ready` output 1: loader accepts a word this cycle.
- `pe_clr` output 1: one-cycle clear pulse to every PE's reset.
- `pe_inst` output INST_W: broadcast instruction bus.
- `pe_init` output NUM_PE: one-hot write strobe.
- `pe_run` output 1: broadcast run strobe.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `done`; set when `ctx_len` was illegal.
- `abort` input 1: present only with `PE_CFG_LOADER_ABORT_EN`.

## Operation

- States: IDLE, CLEAR, LOAD, FLUSH, RUN, DRAIN, DONE.
- IDLE: `start`=1 latches `ctx_len`.
  - If `ctx_len`==0 or `ctx_len`>DEPTH, go to DONE with `err`=1.
  - Otherwise go to CLEAR.
- CLEAR: one cycle with `pe_clr`=1, then go to LOAD.
- LOAD: `in_ready`=1, driven combinationally from the state.
  - Beat order is PE-major: PE0 contexts 0..ctx_len-1, then PE1, and so on.
  - Counter `ctx_idx` wraps at `ctx_len-1` and increments `pe_idx`.
  - Total beats = NUM_PE*ctx_len.
  - On an accepted beat, the following cycle has `pe_inst`=`in_data` (registered) and `pe_init`=one-hot(`pe_idx`).
  - Otherwise `pe_init`=0 and `pe_inst` holds its last value.
  - Acceptance of the final beat moves the FSM to FLUSH; `in_ready` is 0 from that next cycle.
  - `in_valid` gaps stall LOAD indefinitely with no timeout.
- FLUSH: one cycle carrying the last `pe_init` write. `pe_run`=0 here, because a PE gives init priority over run.
- RUN: `pe_run`=1 for exactly `ctx_len` consecutive cycles, counted down by `run_cnt`.
- DRAIN: 2 cycles with `pe_run`=0, letting the PE result registers settle.
- DONE: `done`=1 for one cycle, then return to IDLE. `err` is valid only while `done`=1 and is 0 otherwise.
- `start` outside IDLE is ignored.
- Changes to `ctx_len` outside IDLE are ignored.

## Timing

- Reset values: state=IDLE, `in_ready`=0, `pe_clr`=0, `pe_inst`=0, `pe_init`=0, `pe_run`=0, `busy`=0, `done`=0, `err`=0. All counters are 0.
- `rst` mid-job: the FSM returns to IDLE the next cycle with all outputs at reset values. No `done` is produced.
- Legal job timeline, with `start` accepted at cycle T:
  - `pe_clr` high at T+1.
  - `in_ready` high from T+2.
  - Last beat accepted at cycle K: final `pe_init` at K+1 (FLUSH).
  - `pe_run` high on K+2..K+1+ctx_len.
  - DRAIN on K+2+ctx_len and K+3+ctx_len.
  - `done` at K+4+ctx_len.
- Illegal `ctx_len`: `done`=`err`=1 at T+1. No `pe_clr`, `in_ready`, `pe_init` or `pe_run` activity.
- Invariants:
  - `pe_init` and `pe_run` are never high in the same cycle.
  - At most one `pe_init` bit is high in any cycle.

## Configuration

- `PE_CFG_LOADER_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in any state other than IDLE or DONE forces the FSM to CLEAR, then DONE, with `err`=1. In that case `pe_clr` pulses at +1 and `done`/`err` at +2.
  - Any partially written PE state is wiped by the clear pulse.
  - `abort` in IDLE or DONE is ignored.
- `PE_CFG_LOADER_ABORT_EN` undefined: no `abort` port. A job runs to completion or until `rst`.

## Test plan

- Legal job: NUM_PE=4, ctx_len=3, 12 beats `in_data`=0x100+n, `in_valid` held high.
  - `pe_clr` at T+1.
  - `pe_init` sequence 0001×3, 0010×3, 0100×3, 1000×3, with `pe_inst` equal to the matching word.
  - `pe_run` high for 3 cycles; `done`=1, `err`=0 at K+7.
- Backpressure: same job with `in_valid` toggling every other cycle.
  - Exactly 12 `pe_init` pulses, no duplicated or skipped word.
  - `pe_run` starts exactly 2 cycles after the last accepted beat.
- Illegal lengths: `ctx_len`=0, then `ctx_len`=17 with DEPTH=16.
  - `done`=`err`=1 at T+1 each time.
  - `in_ready`, `pe_init` and `pe_run` stay 0 throughout.
- Reset mid-LOAD: assert `rst` after 5 beats.
  - All outputs 0 the next cycle.
  - A fresh `start` then completes normally.
- Ignored start: pulse `start` during RUN.
  - No restart; `done` count stays at 1 for the job.
- Abort (`PE_CFG_LOADER_ABORT_EN` defined): `abort` during RUN cycle 2 of 3.
  - `pe_run` drops immediately.
  - `pe_clr` at +1, `done`=`err`=1 at +2.

Source files
------------

// File: rtl/pe_config_loader.sv
// pe_config_loader: streams PE instruction words into per-PE configuration
// buffers (PE-major order), then replays the loaded contexts with a broadcast
// run strobe. Every legal job is bracketed by a clear pulse and a done pulse.
// Optional feature macro: PE_CFG_LOADER_ABORT_EN adds an abort input that
// clears the PEs and ends the job with err=1.
module pe_config_loader #(
    parameter int NUM_PE = 4,
    parameter int INST_W = 28,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef PE_CFG_LOADER_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] ctx_len,
    input  logic                       in_valid,
    input  logic [INST_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       pe_clr,
    output logic [INST_W-1:0]          pe_inst,
    output logic [NUM_PE-1:0]          pe_init,
    output logic                       pe_run,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CL_W = $clog2(DEPTH + 1);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CL_W-1:0]     r_ctx_len;
    logic [CL_W-1:0]     r_ctx_idx;
    logic [PE_W-1:0]     r_pe_idx;
    logic [CL_W-1:0]     r_run_cnt;
    logic                r_drain;
    logic                r_err;
    logic                r_abort_pend;
    logic [INST_W-1:0]   r_pe_inst;
    logic [NUM_PE-1:0]   r_pe_init;

    logic                w_abort;
    logic                w_len_bad;
    logic                w_accept;
    logic                w_ctx_last;
    logic                w_last_beat;

    // One-hot strobe for the PE currently being written.
    function automatic logic [NUM_PE-1:0] onehot(input logic [PE_W-1:0] idx);
        logic [NUM_PE-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef PE_CFG_LOADER_ABORT_EN
    // Abort only has effect while a job is actually in flight.
    assign w_abort = abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_len_bad   = (ctx_len == '0) || (ctx_len > CL_W'(DEPTH));
    // A beat arriving in the same cycle as abort is refused so nothing is
    // written alongside the clear pulse.
    assign in_ready    = (r_state == S_LOAD) && !w_abort;
    assign w_accept    = in_valid && in_ready;
    assign w_ctx_last  = (r_ctx_idx == (r_ctx_len - CL_W'(1)));
    assign w_last_beat = w_ctx_last && (r_pe_idx == PE_W'(NUM_PE - 1));

    assign pe_clr  = (r_state == S_CLEAR);
    assign pe_run  = (r_state == S_RUN);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = (r_state == S_DONE) && r_err;
    assign pe_inst = r_pe_inst;
    assign pe_init = r_pe_init;

    // Next-state decode; abort overrides every in-flight transition.
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_bad) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_CLEAR;
                        end
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (r_abort_pend) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept && w_last_beat) begin
                        w_next = S_FLUSH;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
                S_FLUSH: w_next = S_RUN;
                S_RUN: begin
                    if (r_run_cnt == CL_W'(1)) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DRAIN;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register plus the per-state counters and registered PE bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ctx_len    <= '0;
            r_ctx_idx    <= '0;
            r_pe_idx     <= '0;
            r_run_cnt    <= '0;
            r_drain      <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_pe_inst    <= '0;
            r_pe_init    <= '0;
        end else begin
            r_state   <= w_next;
            r_pe_init <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ctx_len    <= ctx_len;
                        r_err        <= w_len_bad;
                        r_abort_pend <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_ctx_idx <= '0;
                    r_pe_idx  <= '0;
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_pe_inst <= in_data;
                        r_pe_init <= onehot(r_pe_idx);
                        if (w_ctx_last) begin
                            r_ctx_idx <= '0;
                            r_pe_idx  <= r_pe_idx + PE_W'(1);
                        end else begin
                            r_ctx_idx <= r_ctx_idx + CL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_run_cnt <= r_ctx_len;
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt - CL_W'(1);
                    r_drain   <= 1'b0;
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                end
                S_DONE: begin
                    r_err        <= 1'b0;
                    r_drain      <= 1'b0;
                    r_abort_pend <= 1'b0;
                    r_run_cnt    <= '0;
                end
                default: begin
                    r_drain <= 1'b0;
                end
            endcase
            if (w_abort) begin
                r_abort_pend <= 1'b1;
                r_err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader: legal jobs with and without input gaps,
// illegal lengths, reset in the middle of a load, a start pulse during RUN,
// and (when PE_CFG_LOADER_ABORT_EN is defined) abort during RUN.
module tb_pe_config_loader;

    localparam int NUM_PE = 4;
    localparam int INST_W = 28;
    localparam int DEPTH  = 16;
    localparam int CL_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CL_W-1:0]   ctx_len;
    logic              in_valid;
    logic [INST_W-1:0] in_data;
    logic              in_ready;
    logic              pe_clr;
    logic [INST_W-1:0] pe_inst;
    logic [NUM_PE-1:0] pe_init;
    logic              pe_run;
    logic              busy;
    logic              done;
    logic              err;
`ifdef PE_CFG_LOADER_ABORT_EN
    logic              abort;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cnt_run = 0;
    int cnt_done = 0;
    int cnt_ready = 0;
    int viol_overlap = 0;
    int viol_multi = 0;
    logic [NUM_PE-1:0] q_init[$];
    logic [INST_W-1:0] q_inst[$];

    pe_config_loader #(.NUM_PE(NUM_PE), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef PE_CFG_LOADER_ABORT_EN
        .abort    (abort),
`endif
        .start    (start),
        .ctx_len  (ctx_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .pe_clr   (pe_clr),
        .pe_inst  (pe_inst),
        .pe_init  (pe_init),
        .pe_run   (pe_run),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: event counts, write log and invariant violations.
    always @(negedge clk) begin
        if (pe_run) cnt_run++;
        if (done) cnt_done++;
        if (in_ready) cnt_ready++;
        if (pe_init != '0) begin
            q_init.push_back(pe_init);
            q_inst.push_back(pe_inst);
        end
        if ((pe_init != '0) && pe_run) viol_overlap++;
        if ($countones(pe_init) > 1) viol_multi++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive up to `beats` words; returns accepted count. Ends one cycle after
    // the last accepted beat.
    task automatic feed(input int beats, input bit gaps, output int n);
        int budget;
        bit tg;
        bit acc;
        n = 0;
        budget = 0;
        tg = 1'b1;
        while ((n < beats) && (budget < 400)) begin
            in_valid = gaps ? tg : 1'b1;
            tg = ~tg;
            in_data = INST_W'(32'h100 + n);
            acc = in_valid && in_ready;
            tick();
            if (acc) n++;
            budget++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int len, input bit gaps, input bit poke);
        int n;
        int total;
        int base_done;
        int base_run;
        total = NUM_PE * len;
        q_init.delete();
        q_inst.delete();
        base_done = cnt_done;
        base_run = cnt_run;
        start = 1'b1;
        ctx_len = CL_W'(len);
        tick();
        start = 1'b0;
        ctx_len = 5'd7;
        check_eq("clr_pulse", 64'(pe_clr), 64'd1);
        check_eq("clr_no_ready", 64'(in_ready), 64'd0);
        tick();
        check_eq("ready_at_t2", 64'(in_ready), 64'd1);
        feed(total, gaps, n);
        check_eq("beats_accepted", 64'(n), 64'(total));
        check_eq("flush_init", 64'(pe_init), 64'(1 << (NUM_PE - 1)));
        check_eq("flush_inst", 64'(pe_inst), 64'(32'h100 + total - 1));
        check_eq("flush_ready", 64'(in_ready), 64'd0);
        check_eq("flush_run", 64'(pe_run), 64'd0);
        for (int i = 0; i < len; i++) begin
            tick();
            check_eq("run_high", 64'(pe_run), 64'd1);
            if (poke && (i == 1)) begin
                start = 1'b1;
                ctx_len = 5'd0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tick();
        check_eq("drain1", 64'({pe_run, done}), 64'd0);
        tick();
        check_eq("drain2", 64'({pe_run, done}), 64'd0);
        tick();
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_err", 64'(err), 64'd0);
        tick();
        check_eq("idle_after", 64'({busy, done, err}), 64'd0);
        tick();
        check_eq("run_cycles", 64'(cnt_run - base_run), 64'(len));
        check_eq("done_count", 64'(cnt_done - base_done), 64'd1);
        check_eq("init_count", 64'(q_init.size()), 64'(total));
        for (int k = 0; k < q_init.size() && k < total; k++) begin
            check_eq("init_seq", 64'(q_init[k]), 64'(1 << (k / len)));
            check_eq("inst_seq", 64'(q_inst[k]), 64'(32'h100 + k));
        end
    endtask

    task automatic illegal_job(input logic [CL_W-1:0] len);
        int base_run;
        int base_ready;
        q_init.delete();
        base_run = cnt_run;
        base_ready = cnt_ready;
        start = 1'b1;
        ctx_len = len;
        tick();
        start = 1'b0;
        check_eq("bad_done", 64'(done), 64'd1);
        check_eq("bad_err", 64'(err), 64'd1);
        check_eq("bad_no_clr", 64'(pe_clr), 64'd0);
        tick();
        check_eq("bad_after", 64'({busy, done, err}), 64'd0);
        tick();
        check_eq("bad_no_run", 64'(cnt_run - base_run), 64'd0);
        check_eq("bad_no_ready", 64'(cnt_ready - base_ready), 64'd0);
        check_eq("bad_no_init", 64'(q_init.size()), 64'd0);
    endtask

    initial begin
        int n;
        int base_done;
        rst = 1'b1;
        start = 1'b0;
        ctx_len = '0;
        in_valid = 1'b0;
        in_data = '0;
`ifdef PE_CFG_LOADER_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        check_eq("reset_ctrl", 64'({in_ready, pe_clr, pe_run, busy, done, err}), 64'd0);
        check_eq("reset_init", 64'(pe_init), 64'd0);
        check_eq("reset_inst", 64'(pe_inst), 64'd0);
        rst = 1'b0;
        tick();

        run_job(3, 1'b0, 1'b0);
        run_job(3, 1'b1, 1'b0);
        run_job(1, 1'b0, 1'b0);
        illegal_job(5'd0);
        illegal_job(5'd17);

        // Reset after 5 accepted beats of a ctx_len=3 job.
        base_done = cnt_done;
        start = 1'b1;
        ctx_len = 5'd3;
        tick();
        start = 1'b0;
        tick();
        feed(5, 1'b0, n);
        check_eq("rst_beats", 64'(n), 64'd5);
        rst = 1'b1;
        tick();
        check_eq("rst_ctrl", 64'({in_ready, pe_clr, pe_run, busy, done, err}), 64'd0);
        check_eq("rst_init", 64'(pe_init), 64'd0);
        check_eq("rst_inst", 64'(pe_inst), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("rst_no_done", 64'(cnt_done - base_done), 64'd0);
        run_job(3, 1'b0, 1'b0);

        // Start pulse during RUN must be ignored.
        run_job(3, 1'b0, 1'b1);

`ifdef PE_CFG_LOADER_ABORT_EN
        // Abort in RUN cycle 2 of 3.
        start = 1'b1;
        ctx_len = 5'd3;
        tick();
        start = 1'b0;
        tick();
        feed(12, 1'b0, n);
        tick();
        tick();
        check_eq("abort_run_pre", 64'(pe_run), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_run_drop", 64'(pe_run), 64'd0);
        check_eq("abort_clr", 64'(pe_clr), 64'd1);
        tick();
        check_eq("abort_done", 64'({done, err}), 64'd3);
        tick();
        check_eq("abort_idle", 64'({busy, done, err}), 64'd0);
`endif

        check_eq("inv_init_run", 64'(viol_overlap), 64'd0);
        check_eq("inv_onehot", 64'(viol_multi), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
